// File: rtl/tbus_mem_responder.sv
// Trinity-bus responder: one request at a time, masked 64-bit read/write on a local word array,
// completion pulse LATENCY cycles after accept.
module tbus_mem_responder #(
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tbus_index_valid,
   output logic        tbus_index_ready,
   input  logic [63:0] tbus_index,
   input  logic [63:0] tbus_write_data,
   input  logic [63:0] tbus_write_mask,
   input  logic [1:0]  tbus_operation_type,
   output logic [63:0] tbus_read_data,
   output logic        tbus_operation_done,
   input  logic        flush,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);
   localparam bit Lat1 = (LATENCY == 1);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [AW-1:0]   word_q;
   logic [63:0]     data_q;
   logic [63:0]     mask_q;
   logic            write_q;
   logic            done_q;
   logic [63:0]     rdata_q;
   logic [63:0]     mem_q [DEPTH];

   logic            accept;
   logic            fire_from_accept;
   logic            fire_from_wait;
   logic            fire;
   logic [AW-1:0]   fire_word;
   logic [63:0]     fire_data;
   logic [63:0]     fire_mask;
   logic            fire_write;
   logic [63:0]     fire_wdata;

   assign tbus_index_ready = (state_q == StIdle) & ~flush & ~reset;
   assign accept           = tbus_index_valid & tbus_index_ready;

   // The completing edge is either the accept edge (LATENCY==1) or the last WAIT cycle;
   // flush on that cycle suppresses the completion.
   assign fire_from_accept = accept & Lat1;
   assign fire_from_wait   = (state_q == StWait) & (cnt_q == CW'(1)) & ~flush;
   assign fire             = fire_from_accept | fire_from_wait;

   assign fire_word  = fire_from_accept ? tbus_index[3 +: AW] : word_q;
   assign fire_data  = fire_from_accept ? tbus_write_data : data_q;
   assign fire_mask  = fire_from_accept ? tbus_write_mask : mask_q;
   assign fire_write = fire_from_accept ? (tbus_operation_type == 2'b01) : write_q;
   assign fire_wdata = (mem_q[fire_word] & ~fire_mask) | (fire_data & fire_mask);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         word_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  word_q  <= tbus_index[3 +: AW];
                  data_q  <= tbus_write_data;
                  mask_q  <= tbus_write_mask;
                  write_q <= (tbus_operation_type == 2'b01);
                  cnt_q   <= CntInit;
                  state_q <= Lat1 ? StDone : StWait;
               end
            end
            StWait: begin
               if (flush) begin
                  state_q <= StIdle;
               end else if (cnt_q == CW'(1)) begin
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         if (fire) begin
            done_q  <= 1'b1;
            rdata_q <= fire_write ? 64'd0 : mem_q[fire_word];
         end
      end
   end

   // Array is deliberately not reset.
   always_ff @(posedge clock) begin
      if (fire && fire_write) begin
         mem_q[fire_word] <= fire_wdata;
      end
   end

   assign tbus_read_data      = rdata_q;
   assign tbus_operation_done = done_q;
   assign busy                = (state_q != StIdle);

endmodule
